// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, and an optional
// 2-entry skid buffer. Control payload reads as zero when the head is invalid.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic              accept;
  logic              drain;
  logic              head_vld;
  logic [CTRL_W-1:0] head_ctrl;
  logic [DATA_W-1:0] head_data;

  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign out_valid = head_vld;
  assign out_ctrl  = head_vld ? head_ctrl : '0;
  assign out_data  = head_data;

  generate
    if (SKID != 0) begin : g_skid
      localparam logic [1:0] ST_EMPTY = 2'd0;
      localparam logic [1:0] ST_ONE   = 2'd1;
      localparam logic [1:0] ST_TWO   = 2'd2;

      logic [1:0]        state_q, state_d;
      logic              in_ready_q, in_ready_d;
      logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d, skid_ctrl_q, skid_ctrl_d;
      logic [DATA_W-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;

      always_comb begin
        state_d     = state_q;
        head_ctrl_d = head_ctrl_q;
        head_data_d = head_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              state_d     = ST_ONE;
              head_ctrl_d = in_ctrl;
              head_data_d = in_data;
            end
          end
          ST_ONE: begin
            if (accept && drain) begin
              head_ctrl_d = in_ctrl;
              head_data_d = in_data;
            end else if (accept) begin
              state_d     = ST_TWO;
              skid_ctrl_d = in_ctrl;
              skid_data_d = in_data;
            end else if (drain) begin
              state_d     = ST_EMPTY;
              head_ctrl_d = '0;
            end
          end
          ST_TWO: begin
            // in_ready is low here, so only the drain side can move
            if (drain) begin
              state_d     = ST_ONE;
              head_ctrl_d = skid_ctrl_q;
              head_data_d = skid_data_q;
              skid_ctrl_d = '0;
            end
          end
          default: begin
            state_d     = ST_EMPTY;
            head_ctrl_d = '0;
            skid_ctrl_d = '0;
          end
        endcase
        if (flush) begin
          state_d     = ST_EMPTY;
          head_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
        // registered ready: computed from next state, so no out_ready -> in_ready path
        in_ready_d = (state_d != ST_TWO);
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          head_ctrl_q <= '0;
          head_data_q <= '0;
          skid_ctrl_q <= '0;
          skid_data_q <= '0;
        end else begin
          state_q     <= state_d;
          in_ready_q  <= in_ready_d;
          head_ctrl_q <= head_ctrl_d;
          head_data_q <= head_data_d;
          skid_ctrl_q <= skid_ctrl_d;
          skid_data_q <= skid_data_d;
        end
      end

      assign in_ready  = in_ready_q;
      assign head_vld  = (state_q != ST_EMPTY);
      assign head_ctrl = head_ctrl_q;
      assign head_data = head_data_q;
    end else begin : g_flop
      logic              vld_q, vld_d;
      logic [CTRL_W-1:0] ctrl_q, ctrl_d;
      logic [DATA_W-1:0] data_q, data_d;

      always_comb begin
        vld_d  = vld_q;
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (flush) begin
          vld_d  = 1'b0;
          ctrl_d = '0;
        end else if (accept) begin
          vld_d  = 1'b1;
          ctrl_d = in_ctrl;
          data_d = in_data;
        end else if (drain) begin
          vld_d  = 1'b0;
          ctrl_d = '0;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q  <= 1'b0;
          ctrl_q <= '0;
          data_q <= '0;
        end else begin
          vld_q  <= vld_d;
          ctrl_q <= ctrl_d;
          data_q <= data_d;
        end
      end

      assign in_ready  = !vld_q | out_ready;
      assign head_vld  = vld_q;
      assign head_ctrl = ctrl_q;
      assign head_data = data_q;
    end
  endgenerate

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr)
      stall_cnt_d = '0;
    else if (out_valid && !out_ready && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, plain, skid with 4-bit counter)
// share stimulus; a per-instance scoreboard tracks every accepted beat.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, out_ready, stall_clr;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic [2:0]    rdy, ov;
  logic [2:0][CW-1:0] oc;
  logic [2:0][DW-1:0] od;
  logic [15:0]   sc0, sc1;
  logic [3:0]    sc4;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc[0]), .out_data(od[0]), .stall_cnt(sc0), .stall_clr(stall_clr));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_flop (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc[1]), .out_data(od[1]), .stall_cnt(sc1), .stall_clr(stall_clr));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
    .out_ctrl(oc[2]), .out_data(od[2]), .stall_cnt(sc4), .stall_clr(stall_clr));

  typedef struct packed {
    logic [1:0]    k;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;
  beat_t sbq[$];

  typedef struct {
    logic iv; logic [CW-1:0] ic; logic [DW-1:0] id; logic ordy; logic fl;
    logic erdy; logic eov; logic [CW-1:0] eoc; logic [DW-1:0] eod; logic [15:0] esc;
  } vec_t;
  vec_t tv[20];

  function automatic vec_t mk(logic iv, logic [CW-1:0] ic, logic [DW-1:0] id, logic ordy,
                              logic fl, logic erdy, logic eov, logic [CW-1:0] eoc,
                              logic [DW-1:0] eod, logic [15:0] esc);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.erdy = erdy; v.eov = eov; v.eoc = eoc; v.eod = eod; v.esc = esc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // drive at the falling edge, settle 1 time unit before looking at outputs
  task automatic drv(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                     input logic ordy, input logic fl, input logic clr);
    in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy; flush = fl; stall_clr = clr;
    #1;
  endtask

  // scoreboard update for the handshakes that the coming rising edge will perform
  task automatic tick();
    int idx;
    beat_t b;
    for (int k = 0; k < 3; k++) begin
      if (!ov[k]) chk($sformatf("gate%0d", k), 64'(oc[k]), 64'h0);
      if (ov[k] && out_ready) begin
        idx = -1;
        for (int i = 0; i < sbq.size(); i++)
          if (idx < 0 && sbq[i].k == 2'(k)) idx = i;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL sb%0d_extra act=%0h exp=none", k, od[k]);
        end else begin
          if (od[k] !== sbq[idx].d || oc[k] !== sbq[idx].c) begin
            errors++;
            $display("FAIL sb%0d_beat act=%0h/%0h exp=%0h/%0h", k, oc[k], od[k],
                     sbq[idx].c, sbq[idx].d);
          end
          sbq.delete(idx);
        end
      end
    end
    if (flush) sbq.delete();
    else
      for (int k = 0; k < 3; k++)
        if (in_valid && rdy[k]) begin
          b.k = 2'(k); b.c = in_ctrl; b.d = in_data;
          sbq.push_back(b);
        end
    @(negedge clk);
  endtask

  initial begin
    tv[0]  = mk(1, 8'h81, 32'h10, 1, 0, 1, 0, 8'h00, 32'h0,  16'd0);
    tv[1]  = mk(1, 8'h81, 32'h11, 1, 0, 1, 1, 8'h81, 32'h10, 16'd0);
    tv[2]  = mk(1, 8'h81, 32'h12, 1, 0, 1, 1, 8'h81, 32'h11, 16'd0);
    tv[3]  = mk(1, 8'h81, 32'h13, 1, 0, 1, 1, 8'h81, 32'h12, 16'd0);
    tv[4]  = mk(0, 8'h81, 32'h13, 1, 0, 1, 1, 8'h81, 32'h13, 16'd0);
    tv[5]  = mk(0, 8'h00, 32'h0,  1, 0, 1, 0, 8'h00, 32'h0,  16'd0);
    tv[6]  = mk(1, 8'h42, 32'hA,  0, 0, 1, 0, 8'h00, 32'h0,  16'd0);
    tv[7]  = mk(1, 8'h42, 32'hB,  0, 0, 1, 1, 8'h42, 32'hA,  16'd0);
    tv[8]  = mk(1, 8'h42, 32'hC,  0, 0, 0, 1, 8'h42, 32'hA,  16'd1);
    tv[9]  = mk(1, 8'h42, 32'hC,  1, 0, 0, 1, 8'h42, 32'hA,  16'd2);
    tv[10] = mk(1, 8'h42, 32'hC,  1, 0, 1, 1, 8'h42, 32'hB,  16'd2);
    tv[11] = mk(0, 8'h00, 32'h0,  1, 0, 1, 1, 8'h42, 32'hC,  16'd2);
    tv[12] = mk(0, 8'h00, 32'h0,  1, 0, 1, 0, 8'h00, 32'h0,  16'd2);
    tv[13] = mk(1, 8'h3C, 32'h1,  0, 0, 1, 0, 8'h00, 32'h0,  16'd2);
    tv[14] = mk(1, 8'h3C, 32'h2,  0, 0, 1, 1, 8'h3C, 32'h1,  16'd2);
    tv[15] = mk(1, 8'h3C, 32'hDD, 0, 1, 0, 1, 8'h3C, 32'h1,  16'd3);
    tv[16] = mk(0, 8'h00, 32'h0,  0, 0, 1, 0, 8'h00, 32'h0,  16'd4);
    tv[17] = mk(1, 8'h3C, 32'h5,  1, 0, 1, 0, 8'h00, 32'h0,  16'd4);
    tv[18] = mk(1, 8'h3C, 32'h6,  1, 1, 1, 1, 8'h3C, 32'h5,  16'd4);
    tv[19] = mk(0, 8'h00, 32'h0,  1, 0, 1, 0, 8'h00, 32'h0,  16'd4);

    rst = 1'b1; flush = 0; in_valid = 0; out_ready = 0; stall_clr = 0; in_ctrl = '0; in_data = '0;
    #2 rst = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ov%0d", k), 64'(ov[k]), 64'h0);
      chk($sformatf("rst_rdy%0d", k), 64'(rdy[k]), 64'h1);
      chk($sformatf("rst_oc%0d", k), 64'(oc[k]), 64'h0);
    end
    chk("rst_od", 64'(od[0]), 64'h0);
    chk("rst_sc", 64'({sc0, sc1, 12'h0, sc4}), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drv(tv[i].iv, tv[i].ic, tv[i].id, tv[i].ordy, tv[i].fl, 1'b0);
      chk($sformatf("row%0d_rdy", i), 64'(rdy[0]), 64'(tv[i].erdy));
      chk($sformatf("row%0d_ov", i), 64'(ov[0]), 64'(tv[i].eov));
      chk($sformatf("row%0d_oc", i), 64'(oc[0]), 64'(tv[i].eoc));
      if (tv[i].eov) chk($sformatf("row%0d_od", i), 64'(od[0]), 64'(tv[i].eod));
      chk($sformatf("row%0d_sc", i), 64'(sc0), 64'(tv[i].esc));
      tick();
    end

    // plain register: ready follows !out_valid | out_ready while out_ready toggles
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 8'h66, 32'(32'h20 + (i + 1) / 2), (i % 2 == 0), 1'b0, 1'b0);
      chk($sformatf("tog%0d_rdy", i), 64'(rdy[1]), 64'(i % 2 == 0));
      chk($sformatf("tog%0d_ov", i), 64'(ov[1]), 64'(i > 0));
      if (i > 0) chk($sformatf("tog%0d_od", i), 64'(od[1]), 64'(32'h20 + (i - 1) / 2));
      tick();
    end
    repeat (3) begin
      drv(1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
    end

    // stall counter: count, clear, saturate, survive flush
    drv(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b1); tick();
    chk("clr0_sc0", 64'(sc0), 64'd0);
    chk("clr0_sc4", 64'(sc4), 64'd0);
    drv(1'b1, 8'h11, 32'h77, 1'b0, 1'b0, 1'b0); tick();
    repeat (5) begin
      drv(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    end
    chk("stall5_sc0", 64'(sc0), 64'd5);
    chk("stall5_sc1", 64'(sc1), 64'd5);
    chk("stall5_sc4", 64'(sc4), 64'd5);
    drv(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b1); tick();
    chk("clr1_sc0", 64'(sc0), 64'd0);
    repeat (20) begin
      drv(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    end
    chk("stall20_sc0", 64'(sc0), 64'd20);
    chk("sat_sc4", 64'(sc4), 64'd15);
    drv(1'b0, 8'h0, 32'h0, 1'b0, 1'b1, 1'b0); tick();
    chk("flush_sc0", 64'(sc0), 64'd21);
    chk("flush_sc4", 64'(sc4), 64'd15);
    chk("flush_ov", 64'(ov), 64'h0);
    chk("flush_rdy", 64'(rdy[0]), 64'h1);
    drv(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    chk("idle_sc0", 64'(sc0), 64'd21);

    // async reset while the skid instance holds two entries
    drv(1'b1, 8'h99, 32'h90, 1'b0, 1'b0, 1'b0); tick();
    drv(1'b1, 8'h99, 32'h91, 1'b0, 1'b0, 1'b0); tick();
    drv(1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("two_rdy", 64'(rdy[0]), 64'h0);
    #1 rst = 1'b0;
    #1;
    chk("arst_ov", 64'(ov), 64'h0);
    chk("arst_oc", 64'({oc[0], oc[1], oc[2]}), 64'h0);
    chk("arst_sc", 64'({sc0, sc1, 12'h0, sc4}), 64'h0);
    chk("arst_rdy", 64'({rdy[0], rdy[2]}), 64'h3);
    sbq.delete();
    @(negedge clk);
    rst = 1'b1;
    drv(1'b1, 8'h5A, 32'hA5, 1'b1, 1'b0, 1'b0); tick();
    drv(1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("post_ov", 64'(ov[0]), 64'h1);
    chk("post_od", 64'(od[0]), 64'hA5);
    chk("post_oc", 64'(oc[0]), 64'h5A);
    tick();
    drv(1'b0, 8'h0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    chk("sb_left", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register that replaces the fixed per-stage latch blocks between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake (stall backpressure), synchronous flush with bubble insertion, and an optional 2-entry skid buffer so `in_ready` is registered.
- Includes a saturating stall-cycle counter for performance monitoring.
- Payload is split into control bits (zeroed on bubble/flush) and data bits (not cleared, to save reset/flush logic).

Parameters:
- DATA_W, 32, width of datapath payload (e.g. alu_result, rd2, pc_plus4); not cleared on flush.
- CTRL_W, 8, width of control payload (e.g. reg_write, mem_write, result_src, rd); forced 0 when entry invalid.
- SKID, 1, 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- CNT_W, 16, width of saturating stall counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- flush  input  1  synchronous flush; kills all held entries and the input beat this cycle.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_ctrl  input  CTRL_W  upstream control payload.
- in_data  input  DATA_W  upstream data payload.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head this cycle.
- out_ctrl  output  CTRL_W  head control payload; all-zero whenever out_valid=0.
- out_data  output  DATA_W  head data payload; undefined-but-stable when out_valid=0.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Reset (rst=0, async): all valid bits 0; ctrl and data registers 0; stall_cnt 0; in_ready=1 (SKID=1 register resets to 1; SKID=0 follows from out_valid=0).
- Latency: an accepted beat appears on out_* the next cycle. Throughput is 1 beat/cycle when out_ready stays high.
- Output ctrl gating: out_ctrl = head_ctrl when head valid, else 0. A bubble therefore carries reg_write=0 and mem_write=0.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - On accept, head <= input and valid=1.
  - Else on drain, valid <= 0 and ctrl <= 0.
- SKID=1: states EMPTY (0 entries), ONE (head only), TWO (head + skid); in_ready = (state != TWO), registered.
  - EMPTY: accept -> ONE, with the input loaded into head.
  - ONE:
    - accept & drain -> ONE, head <= input.
    - accept & !drain -> TWO, skid <= input.
    - !accept & drain -> EMPTY.
    - otherwise hold.
  - TWO: in_ready=0, so no accept. Drain -> ONE with head <= skid; otherwise hold.
  - Ordering is strict FIFO; no beat is dropped or duplicated under any out_ready pattern.
- Flush (priority over every other event except reset):
  - Next cycle all entries are invalid, state EMPTY, and stored ctrl is 0.
  - An input accepted in the flush cycle is discarded.
  - Any drain in the flush cycle still completes normally for the downstream side, because out_* are valid that cycle.
  - After flush, in_ready=1.
- stall_cnt:
  - Increments each cycle out_valid & !out_ready; saturates at all-ones with no wrap.
  - stall_clr has priority over increment and takes effect next cycle.
  - Flush does not clear stall_cnt.
- Reset asserted mid-transfer: entries are lost immediately and outputs go to reset values asynchronously. Deassertion is synchronised externally.
- No combinational path from in_* to out_* in either mode. With SKID=1 there is also no combinational path from out_ready to in_ready.

Test Plan:
- Reset then stream 4 beats, in_data=0x10..0x13, ctrl=0x81, out_ready=1 -> out_valid rises one cycle after the first beat; outputs 0x10..0x13 in order, one per cycle; stall_cnt=0.
- SKID=1, out_ready=0 while 3 beats are offered (0xA,0xB,0xC) -> 0xA and 0xB accepted; in_ready=0 from the cycle after 0xB; 0xC held upstream. Raising out_ready -> 0xA,0xB,0xC delivered in order, none lost.
- Stall of 5 cycles with head valid -> stall_cnt=5. Then stall_clr pulse -> 0. With CNT_W=4, hold a stall of 20 cycles -> stall_cnt stays 15.
- State TWO, assert flush together with in_valid=1 (data 0xDD) -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1; 0xDD never appears at the output.
- SKID=0, out_ready toggling 1,0,1,0 with continuous in_valid -> in_ready mirrors `!out_valid | out_ready` each cycle; the beat sequence is preserved.
- Assert rst mid-stream while state=TWO -> out_valid=0 and out_ctrl=0 immediately (asynchronously), stall_cnt=0; after release, the first accepted beat emerges normally.
